// File: rtl/dcache_pkg.sv
// Shared types and field positions for the L1 data-cache miss controller.
package dcache_pkg;
   localparam int unsigned TAG_W     = 23;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned LINE_W    = 256;
   localparam int unsigned OFFSET_W  = 5;
   localparam int unsigned TAGF_W    = TAG_W + 2;
   localparam int unsigned VALID_BIT = 24;
   localparam int unsigned DIRTY_BIT = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MISS,
      ST_WRITEBACK,
      ST_READMISS,
      ST_READMISSOK
   } state_e;
endpackage

// File: rtl/dcache_controller_if.sv
// Controller-to-SRAM bus; names are seen from the controller (initiator) side.
interface dcache_controller_if;
   import dcache_pkg::*;

   logic [IDX_W-1:0]  sram_addr_o;
   logic [TAGF_W-1:0] sram_tag_o;
   logic [LINE_W-1:0] sram_data_o;
   logic              sram_enable_o;
   logic              sram_write_o;
   logic [TAGF_W-1:0] sram_tag_i;
   logic [LINE_W-1:0] sram_data_i;
   logic              sram_hit_i;

   modport master (
      output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i
   );

   modport slave (
      input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i
   );
endinterface

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a cache line and builds the line with that word replaced.
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [2:0]        word_sel_i,
   input  logic [31:0]       word_i,
   output logic [31:0]       word_o,
   output logic [LINE_W-1:0] line_o
);
   logic [7:0] bit_base;

   always_comb begin
      bit_base = {word_sel_i, 5'b0};
      word_o   = line_i[bit_base +: 32];
      line_o   = line_i;
      line_o[bit_base +: 32] = word_i;
   end
endmodule

// File: rtl/dcache_controller.sv
// Miss handler for the 2-way L1 D-cache: stalls the CPU, writes back dirty
// victims, refills lines from memory and merges CPU word writes.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [31:0]         cpu_addr_i,
   input  logic [31:0]         cpu_data_i,
   input  logic                cpu_MemRead_i,
   input  logic                cpu_MemWrite_i,
   output logic [31:0]         cpu_data_o,
   output logic                cpu_stall_o,
   output logic [31:0]         mem_addr_o,
   output logic [LINE_W-1:0]   mem_data_o,
   output logic                mem_enable_o,
   output logic                mem_write_o,
   input  logic [LINE_W-1:0]   mem_data_i,
   input  logic                mem_ack_i,
   dcache_controller_if.master sram
);
   state_e            state_q, state_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_q, mem_write_d;

   logic              req, wr, hit_ok, victim_dirty;
   logic [TAG_W-1:0]  addr_tag;
   logic [IDX_W-1:0]  idx;
   logic [LINE_W-1:0] merged_line;
   logic              addr_lsb_unused;

   assign req             = cpu_MemRead_i | cpu_MemWrite_i;
   assign wr              = cpu_MemWrite_i;
   assign addr_tag        = cpu_addr_i[31:9];
   assign idx             = cpu_addr_i[8:5];
   assign addr_lsb_unused = ^cpu_addr_i[1:0];
   assign victim_dirty    = sram.sram_tag_i[VALID_BIT] & sram.sram_tag_i[DIRTY_BIT];
   assign hit_ok          = sram.sram_hit_i & (state_q == ST_IDLE || state_q == ST_READMISSOK);
   assign cpu_stall_o     = req & ~hit_ok;

   dcache_word_merge u_word_merge (
      .line_i     (sram.sram_data_i),
      .word_sel_i (cpu_addr_i[4:2]),
      .word_i     (cpu_data_i),
      .word_o     (cpu_data_o),
      .line_o     (merged_line)
   );

   always_comb begin
      state_d            = state_q;
      mem_addr_d         = mem_addr_q;
      mem_data_d         = mem_data_q;
      mem_enable_d       = mem_enable_q;
      mem_write_d        = mem_write_q;
      sram.sram_addr_o   = idx;
      sram.sram_enable_o = req;
      sram.sram_write_o  = 1'b0;
      sram.sram_data_o   = merged_line;
      sram.sram_tag_o    = {1'b1, 1'b0, addr_tag};

      unique case (state_q)
         ST_IDLE: begin
            if (req && sram.sram_hit_i) begin
               if (wr) begin
                  sram.sram_write_o = 1'b1;
                  sram.sram_tag_o   = {1'b1, 1'b1, addr_tag};
               end
            end else if (req) begin
               state_d = ST_MISS;
            end
         end
         ST_MISS: begin
            mem_enable_d = 1'b1;
            if (victim_dirty) begin
               mem_write_d = 1'b1;
               mem_addr_d  = {sram.sram_tag_i[TAG_W-1:0], idx, {OFFSET_W{1'b0}}};
               mem_data_d  = sram.sram_data_i;
               state_d     = ST_WRITEBACK;
            end else begin
               mem_write_d = 1'b0;
               mem_addr_d  = {cpu_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
               state_d     = ST_READMISS;
            end
         end
         ST_WRITEBACK: begin
            if (mem_ack_i) begin
               mem_write_d = 1'b0;
               mem_addr_d  = {cpu_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
               state_d     = ST_READMISS;
            end
         end
         ST_READMISS: begin
            if (mem_ack_i) begin
               sram.sram_write_o = 1'b1;
               sram.sram_data_o  = mem_data_i;
               sram.sram_tag_o   = {1'b1, 1'b0, addr_tag};
               mem_enable_d      = 1'b0;
               state_d           = ST_READMISSOK;
            end
         end
         ST_READMISSOK: begin
            // Refilled line now hits; a pending store merges into it and marks it dirty.
            if (req && wr && sram.sram_hit_i) begin
               sram.sram_write_o = 1'b1;
               sram.sram_tag_o   = {1'b1, 1'b1, addr_tag};
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller with a behavioural 2-way LRU SRAM and a latency-L memory.
module tb_dcache_controller;
   logic         clk_i, rst_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
   logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_enable_o, mem_write_o, mem_ack_i;

   dcache_controller_if sif ();

   dcache_controller dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack_i),
      .sram           (sif.master)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   typedef struct {
      string        tag;
      logic [255:0] exp;
   } sb_item_t;
   sb_item_t sb_q[$];

   task automatic sb_push(input string tag, input logic [255:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_pop(input logic [255:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check_eq("scoreboard_empty", 256'd0, 256'd1);
      end else begin
         it = sb_q.pop_front();
         check_eq(it.tag, obs, it.exp);
      end
   endtask

   // Behavioural SRAM: two ways, one LRU bit per set, writes on the rising edge.
   logic [24:0]  m_tag  [2][16];
   logic [255:0] m_line [2][16];
   logic         m_lru  [16];
   logic [3:0]   s_idx;
   logic         s_hit, s_hway, s_way;
   logic         pl_clear, pl_en, pl_way, pl_lru;
   logic [3:0]   pl_idx;
   logic [24:0]  pl_tag;
   logic [255:0] pl_line;

   always_comb begin
      s_idx  = sif.sram_addr_o;
      s_hit  = 1'b0;
      s_hway = 1'b0;
      for (int w = 0; w < 2; w++) begin
         if (m_tag[w][s_idx][24] && m_tag[w][s_idx][22:0] == cpu_addr_i[31:9]) begin
            s_hit  = 1'b1;
            s_hway = 1'(w);
         end
      end
      s_way           = s_hit ? s_hway : m_lru[s_idx];
      sif.sram_hit_i  = sif.sram_enable_o & s_hit;
      sif.sram_tag_i  = m_tag[s_way][s_idx];
      sif.sram_data_i = m_line[s_way][s_idx];
   end

   always @(posedge clk_i) begin
      if (pl_clear) begin
         for (int s = 0; s < 16; s++) begin
            m_tag[0][s]  <= '0;
            m_tag[1][s]  <= '0;
            m_line[0][s] <= '0;
            m_line[1][s] <= '0;
            m_lru[s]     <= 1'b0;
         end
      end else if (pl_en) begin
         m_tag[pl_way][pl_idx]  <= pl_tag;
         m_line[pl_way][pl_idx] <= pl_line;
         m_lru[pl_idx]          <= pl_lru;
      end else if (sif.sram_write_o) begin
         m_tag[s_way][s_idx]  <= sif.sram_tag_o;
         m_line[s_way][s_idx] <= sif.sram_data_o;
         m_lru[s_idx]         <= ~s_way;
      end else if (sif.sram_enable_o && s_hit) begin
         m_lru[s_idx] <= ~s_hway;
      end
   end

   // Memory: ack in the L-th cycle a request is visible; a read right after a
   // write-back pays one extra bus-turnaround cycle.
   int unsigned  mem_lat = 10;
   logic [255:0] refill_line;
   logic         spur_ack;
   logic [31:0]  txn_addr[$];
   bit           txn_wr[$];
   logic [255:0] txn_data[$];
   bit           m_busy, m_cur_wr, m_last_wr;
   int unsigned  m_cnt, m_need;

   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      m_busy     = 1'b0;
      m_last_wr  = 1'b0;
      m_cnt      = 0;
      m_need     = 0;
      m_cur_wr   = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         mem_ack_i = spur_ack;
         if (!rst_i) begin
            m_busy = 1'b0;
         end else begin
            if (!m_busy && mem_enable_o) begin
               m_busy   = 1'b1;
               m_cnt    = 1;
               m_cur_wr = mem_write_o;
               m_need   = mem_lat + ((!mem_write_o && m_last_wr) ? 1 : 0);
               txn_addr.push_back(mem_addr_o);
               txn_wr.push_back(mem_write_o);
               txn_data.push_back(mem_data_o);
            end
            if (m_busy) begin
               if (m_cnt == m_need) begin
                  mem_ack_i = 1'b1;
                  if (!m_cur_wr) mem_data_i = refill_line;
                  m_busy    = 1'b0;
                  m_last_wr = m_cur_wr;
               end else begin
                  m_cnt++;
               end
            end
         end
      end
   end

   function automatic logic [255:0] pat(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   task automatic preload(input logic way, input logic [3:0] idx, input logic [24:0] tag,
                          input logic [255:0] line, input logic lru);
      @(negedge clk_i);
      pl_en   = 1'b1;
      pl_way  = way;
      pl_idx  = idx;
      pl_tag  = tag;
      pl_line = line;
      pl_lru  = lru;
      @(posedge clk_i);
      #1;
      pl_en = 1'b0;
   endtask

   task automatic run_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                          output int unsigned stalls, output logic [31:0] rdata);
      bit done;
      done   = 1'b0;
      stalls = 0;
      rdata  = '0;
      @(negedge clk_i);
      cpu_addr_i     = a;
      cpu_MemRead_i  = rd;
      cpu_MemWrite_i = wr;
      cpu_data_i     = d;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (!cpu_stall_o) begin
            done  = 1'b1;
            rdata = cpu_data_o;
            break;
         end
         stalls++;
         @(negedge clk_i);
      end
      if (!done) check_eq("req_timeout", 256'd0, 256'd1);
      @(posedge clk_i);
      #1;
      cpu_MemRead_i  = 1'b0;
      cpu_MemWrite_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned  st, base;
      logic [31:0]  rd;
      logic [255:0] line0, exp_line, victim;
      bit           seen;

      cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
      spur_ack = 1'b0; refill_line = '0;
      pl_clear = 1'b1; pl_en = 1'b0; pl_way = 1'b0; pl_idx = '0; pl_tag = '0; pl_line = '0; pl_lru = 1'b0;
      rst_i = 1'b1;
      #1 rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 pl_clear = 1'b0;

      check_eq("rst_mem_enable", 256'(mem_enable_o), 256'd0);
      check_eq("rst_mem_write", 256'(mem_write_o), 256'd0);
      check_eq("rst_mem_addr", 256'(mem_addr_o), 256'd0);
      check_eq("rst_mem_data", mem_data_o, 256'd0);
      check_eq("rst_sram_write", 256'(sif.sram_write_o), 256'd0);
      check_eq("rst_stall", 256'(cpu_stall_o), 256'd0);
      check_eq("rst_sram_enable", 256'(sif.sram_enable_o), 256'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Read hit: set 3, way 0, tag 0x12, word 2
      line0 = pat(32'h1000_0000);
      line0[2*32 +: 32] = 32'hDEAD_BEEF;
      preload(1'b0, 4'd3, {1'b1, 1'b0, 23'h12}, line0, 1'b1);
      base = txn_addr.size();
      sb_push("rdhit_data", 256'(32'hDEAD_BEEF));
      sb_push("rdhit_stall", 256'd0);
      run_req(32'h0000_2468, 1'b1, 1'b0, '0, st, rd);
      sb_pop(256'(rd));
      sb_pop(256'(st));
      check_eq("rdhit_no_mem", 256'(txn_addr.size()), 256'(base));

      // Write hit: word 1 replaced, line becomes dirty
      exp_line = line0;
      exp_line[1*32 +: 32] = 32'hCAFE_F00D;
      sb_push("wrhit_stall", 256'd0);
      run_req(32'h0000_2464, 1'b0, 1'b1, 32'hCAFE_F00D, st, rd);
      sb_pop(256'(st));
      check_eq("wrhit_line", m_line[0][3], exp_line);
      check_eq("wrhit_tag", 256'(m_tag[0][3]), 256'({1'b1, 1'b1, 23'h12}));
      check_eq("wrhit_no_mem", 256'(txn_addr.size()), 256'(base));

      // Clean read miss, set 2 empty
      refill_line = pat(32'hA000_0000);
      base = txn_addr.size();
      sb_push("clean_data", 256'(32'hA000_0000));
      sb_push("clean_stall", 256'(2 + mem_lat));
      run_req(32'h0000_0040, 1'b1, 1'b0, '0, st, rd);
      sb_pop(256'(rd));
      sb_pop(256'(st));
      check_eq("clean_txn_count", 256'(txn_addr.size() - base), 256'd1);
      check_eq("clean_txn_addr", 256'(txn_addr[base]), 256'(32'h0000_0040));
      check_eq("clean_txn_wr", 256'(txn_wr[base]), 256'd0);
      check_eq("clean_tag", 256'(m_tag[0][2]), 256'({1'b1, 1'b0, 23'h0}));
      check_eq("clean_line", m_line[0][2], refill_line);

      // Dirty miss: LRU way 0 holds dirty tag 0x7 in set 2
      victim = pat(32'h5000_0000);
      preload(1'b1, 4'd2, {1'b1, 1'b0, 23'h33}, pat(32'h6000_0000), 1'b0);
      preload(1'b0, 4'd2, {1'b1, 1'b1, 23'h7}, victim, 1'b0);
      refill_line = pat(32'hB000_0000);
      base = txn_addr.size();
      sb_push("dirty_data", 256'(32'hB000_0000));
      sb_push("dirty_stall", 256'(3 + 2 * mem_lat));
      run_req(32'h0000_1440, 1'b1, 1'b0, '0, st, rd);
      sb_pop(256'(rd));
      sb_pop(256'(st));
      check_eq("dirty_txn_count", 256'(txn_addr.size() - base), 256'd2);
      check_eq("dirty_wb_addr", 256'(txn_addr[base]), 256'(32'h0000_0E40));
      check_eq("dirty_wb_wr", 256'(txn_wr[base]), 256'd1);
      check_eq("dirty_wb_data", txn_data[base], victim);
      check_eq("dirty_rf_addr", 256'(txn_addr[base+1]), 256'(32'h0000_1440));
      check_eq("dirty_rf_wr", 256'(txn_wr[base+1]), 256'd0);
      check_eq("dirty_tag", 256'(m_tag[0][2]), 256'({1'b1, 1'b0, 23'hA}));

      // Write miss with read and write both high: refill then merge word 3
      refill_line = pat(32'hC000_0000);
      exp_line = refill_line;
      exp_line[3*32 +: 32] = 32'h1122_3344;
      base = txn_addr.size();
      sb_push("wrmiss_stall", 256'(2 + mem_lat));
      run_req(32'h0000_3A8C, 1'b1, 1'b1, 32'h1122_3344, st, rd);
      sb_pop(256'(st));
      check_eq("wrmiss_txn_count", 256'(txn_addr.size() - base), 256'd1);
      check_eq("wrmiss_txn_addr", 256'(txn_addr[base]), 256'(32'h0000_3A80));
      check_eq("wrmiss_tag", 256'(m_tag[0][4]), 256'({1'b1, 1'b1, 23'h1D}));
      check_eq("wrmiss_line", m_line[0][4], exp_line);

      // Reset while waiting for the refill ack
      refill_line = pat(32'hD000_0000);
      @(negedge clk_i);
      cpu_addr_i    = 32'h0000_00A0;
      cpu_MemRead_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (mem_enable_o && !mem_write_o) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("rstmid_reached_readmiss", 256'(seen), 256'd1);
      repeat (3) @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      cpu_MemRead_i = 1'b0;
      #1;
      check_eq("rstmid_mem_enable_async", 256'(mem_enable_o), 256'd0);
      check_eq("rstmid_stall", 256'(cpu_stall_o), 256'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      base = txn_addr.size();
      @(negedge clk_i);
      spur_ack = 1'b1;
      @(posedge clk_i);
      #2;
      check_eq("spur_ack_sram_write", 256'(sif.sram_write_o), 256'd0);
      @(negedge clk_i);
      spur_ack = 1'b0;
      @(posedge clk_i);
      #2;
      check_eq("spur_ack_mem_enable", 256'(mem_enable_o), 256'd0);
      check_eq("spur_ack_no_txn", 256'(txn_addr.size()), 256'(base));
      sb_push("fresh_data", 256'(32'hD000_0000));
      sb_push("fresh_stall", 256'(2 + mem_lat));
      run_req(32'h0000_00A0, 1'b1, 1'b0, '0, st, rd);
      sb_pop(256'(rd));
      sb_pop(256'(st));
      check_eq("fresh_txn_count", 256'(txn_addr.size() - base), 256'd1);
      check_eq("fresh_txn_addr", 256'(txn_addr[base]), 256'(32'h0000_00A0));
      check_eq("fresh_tag", 256'(m_tag[0][5]), 256'({1'b1, 1'b0, 23'h0}));

      repeat (2) @(posedge clk_i);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
